// File: rtl/multi_sensor_decoder_if.sv
// multi_sensor_decoder_if
//   Bundles the client request/response handshake and the per-channel sensor
//   driver signals of multi_sensor_decoder.
//   master : client + sensor drivers (drive requests, frames, done/error)
//   slave  : the decoder itself
//   Signals:
//     request_valid/request/device_index  command strobe, byte, target channel
//     busy                                decoder not idle
//     response_valid/response/response_code  result strobe and payload
//     sensor_enable                       per-channel read request (one-hot or 0)
//     sensor_data                         channel i at [40i+39:40i]
//     sensor_done/sensor_error            per-channel frame complete / error
interface multi_sensor_decoder_if #(
  parameter int NUM_SENSORS = 2,
  parameter int IDX_WIDTH   = 5
);
  logic                       request_valid;
  logic [7:0]                 request;
  logic [IDX_WIDTH-1:0]       device_index;
  logic                       busy;
  logic                       response_valid;
  logic [7:0]                 response;
  logic [7:0]                 response_code;
  logic [NUM_SENSORS-1:0]     sensor_enable;
  logic [40*NUM_SENSORS-1:0]  sensor_data;
  logic [NUM_SENSORS-1:0]     sensor_done;
  logic [NUM_SENSORS-1:0]     sensor_error;

  modport master (
    output request_valid, request, device_index,
    output sensor_data, sensor_done, sensor_error,
    input  busy, response_valid, response, response_code, sensor_enable
  );

  modport slave (
    input  request_valid, request, device_index,
    input  sensor_data, sensor_done, sensor_error,
    output busy, response_valid, response, response_code, sensor_enable
  );
endinterface

// File: rtl/multi_sensor_decoder.sv
// multi_sensor_decoder
//   Command front end for up to NUM_SENSORS DHT11-class channels. Decodes a
//   one-byte command per channel, runs single reads with checksum validation
//   and a timeout, and keeps per-channel temperature/humidity monitoring modes
//   serviced by one shared poll timer.
//   Ports:
//     clk  : system clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : multi_sensor_decoder_if.slave (request/response + sensor signals)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | wait for a command; otherwise start a pending poll read
//   DECODE  | classify latched command, update mode or launch a read
//   READ    | hold sensor_enable for the channel until done/error/timeout
//   RESPOND | one-cycle response_valid strobe
module multi_sensor_decoder #(
  parameter int NUM_SENSORS  = 2,
  parameter int IDX_WIDTH    = 5,
  parameter int POLL_PERIOD  = 100_000_000,
  parameter int READ_TIMEOUT = 50_000_000,
  parameter int CNT_WIDTH    = 27
) (
  input logic clk,
  input logic rst,
  multi_sensor_decoder_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DECODE  = 2'd1;
  localparam logic [1:0] S_READ    = 2'd2;
  localparam logic [1:0] S_RESPOND = 2'd3;

  localparam logic [IDX_WIDTH:0]   NUM_S     = (IDX_WIDTH+1)'(NUM_SENSORS);
  localparam logic [CNT_WIDTH-1:0] POLL_LAST = CNT_WIDTH'(POLL_PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST  = CNT_WIDTH'(READ_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic [1:0]             state_q, state_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [IDX_WIDTH-1:0]   ch_q, ch_d;
  logic                   poll_rd_q, poll_rd_d;
  logic [NUM_SENSORS-1:0] temp_q, temp_d;
  logic [NUM_SENSORS-1:0] hum_q, hum_d;
  logic [NUM_SENSORS-1:0] poll_mask_q, poll_mask_d;
  logic [CNT_WIDTH-1:0]   poll_cnt_q, poll_cnt_d;
  logic [CNT_WIDTH-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [7:0]             resp_q, resp_d;
  logic [7:0]             code_q, code_d;

  logic [NUM_SENSORS-1:0] sel_oh, on_mask, off_clr, rd_clr;
  logic [39:0]            frame;
  logic [7:0]             chk_sum;
  logic                   done_sel, err_sel, frame_ok, read_exit, in_range, tick;
  logic [IDX_WIDTH-1:0]   first_ch;

  // Channel select is one-hot; an out-of-range index shifts out to zero.
  assign sel_oh   = NUM_SENSORS'(1) << ch_q;
  assign in_range = {1'b0, ch_q} < NUM_S;
  assign on_mask  = temp_q | hum_q;
  assign done_sel = |(bus.sensor_done & sel_oh);
  assign err_sel  = |(bus.sensor_error & sel_oh);

  always_comb begin
    frame = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (sel_oh[i]) frame = bus.sensor_data[40*i +: 40];
    end
  end

  // Lowest pending channel wins: scan downward so the last hit is the lowest.
  always_comb begin
    first_ch = '0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (poll_mask_q[i]) first_ch = IDX_WIDTH'(i);
    end
  end

  assign chk_sum   = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
  assign frame_ok  = done_sel & ~err_sel & (chk_sum == frame[7:0]);
  assign read_exit = done_sel | err_sel | (tmo_cnt_q == TMO_LAST);

  always_comb begin
    poll_cnt_d = '0;
    tick       = 1'b0;
    if (on_mask != '0) begin
      if (poll_cnt_q == POLL_LAST) tick = 1'b1;
      else                         poll_cnt_d = poll_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    ch_d      = ch_q;
    poll_rd_d = poll_rd_q;
    temp_d    = temp_q;
    hum_d     = hum_q;
    resp_d    = resp_q;
    code_d    = code_q;
    off_clr   = '0;
    rd_clr    = '0;
    tmo_cnt_d = (state_q == S_READ) ? tmo_cnt_q + CNT_ONE : '0;

    case (state_q)
      S_IDLE: begin
        if (bus.request_valid) begin
          cmd_d     = bus.request;
          ch_d      = bus.device_index;
          poll_rd_d = 1'b0;
          state_d   = S_DECODE;
        end else if (poll_mask_q != '0) begin
          ch_d      = first_ch;
          poll_rd_d = 1'b1;
          state_d   = S_READ;
        end
      end
      S_DECODE: begin
        state_d = S_RESPOND;
        if (!in_range) begin
          code_d = 8'hED;
          resp_d = 8'hED;
        end else begin
          case (cmd_q)
            8'h00, 8'h01, 8'h02: state_d = S_READ;
            8'h03: begin
              temp_d = temp_q | sel_oh;
              hum_d  = hum_q & ~sel_oh;
              code_d = 8'h15;
              resp_d = 8'hCA;
            end
            8'h04: begin
              hum_d  = hum_q | sel_oh;
              temp_d = temp_q & ~sel_oh;
              code_d = 8'h16;
              resp_d = 8'hCA;
            end
            8'h05: begin
              code_d = 8'h17;
              resp_d = 8'hEA;
              if ((temp_q & sel_oh) != '0) begin
                temp_d  = temp_q & ~sel_oh;
                off_clr = sel_oh;
                resp_d  = 8'hCA;
              end
            end
            8'h06: begin
              code_d = 8'h18;
              resp_d = 8'hEA;
              if ((hum_q & sel_oh) != '0) begin
                hum_d   = hum_q & ~sel_oh;
                off_clr = sel_oh;
                resp_d  = 8'hCA;
              end
            end
            default: begin
              code_d = 8'hEC;
              resp_d = 8'hEC;
            end
          endcase
        end
      end
      S_READ: begin
        if (read_exit) begin
          state_d = S_RESPOND;
          if (poll_rd_q) begin
            rd_clr = sel_oh;
            if (!frame_ok) begin
              code_d = 8'hE1;
              resp_d = 8'(ch_q);
            end else if ((temp_q & sel_oh) != '0) begin
              code_d = 8'h13;
              resp_d = frame[23:16];
            end else begin
              code_d = 8'h14;
              resp_d = frame[39:32];
            end
          end else begin
            case (cmd_q)
              8'h00: begin
                code_d = 8'h10;
                resp_d = frame_ok ? 8'h11 : 8'h12;
              end
              8'h01: begin
                code_d = frame_ok ? 8'h13 : 8'hE1;
                resp_d = frame_ok ? frame[23:16] : 8'(ch_q);
              end
              default: begin
                code_d = frame_ok ? 8'h14 : 8'hE1;
                resp_d = frame_ok ? frame[39:32] : 8'(ch_q);
              end
            endcase
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A poll read that completes on a tick is re-armed by the new round; a
  // channel being switched off never is.
  assign poll_mask_d = ((poll_mask_q & ~rd_clr) | (tick ? on_mask : '0)) & ~off_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      ch_q        <= '0;
      poll_rd_q   <= 1'b0;
      temp_q      <= '0;
      hum_q       <= '0;
      poll_mask_q <= '0;
      poll_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      resp_q      <= '0;
      code_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      ch_q        <= ch_d;
      poll_rd_q   <= poll_rd_d;
      temp_q      <= temp_d;
      hum_q       <= hum_d;
      poll_mask_q <= poll_mask_d;
      poll_cnt_q  <= poll_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      resp_q      <= resp_d;
      code_q      <= code_d;
    end
  end

  assign bus.busy           = (state_q != S_IDLE);
  assign bus.response_valid = (state_q == S_RESPOND);
  assign bus.response       = resp_q;
  assign bus.response_code  = code_q;
  assign bus.sensor_enable  = (state_q == S_READ) ? sel_oh : '0;

endmodule

// File: tb/tb_multi_sensor_decoder.sv
// tb_multi_sensor_decoder
//   Scoreboard bench: stimulus pushes expected {code,value} pairs predicted by a
//   command-level reference model; a monitor pops and compares on every
//   response strobe. A simple sensor model answers sensor_enable per channel.
module tb_multi_sensor_decoder;
  localparam int NS = 2;
  localparam int IW = 5;
  localparam int PP = 100;
  localparam int RT = 200;
  localparam int CW = 27;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multi_sensor_decoder_if #(.NUM_SENSORS(NS), .IDX_WIDTH(IW)) bus ();

  multi_sensor_decoder #(
    .NUM_SENSORS(NS), .IDX_WIDTH(IW), .POLL_PERIOD(PP),
    .READ_TIMEOUT(RT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc   = 0;
  always @(posedge clk) cyc++;

  logic [15:0] exp_q[$];
  int unsigned stamp_q[$];

  // Reference model state: mode 0=OFF 1=MON_TEMP 2=MON_HUM; kind 0=done 1=error 2=silent
  int          mode_m[NS];
  logic [39:0] frame_m[NS];
  int          kind_m[NS];
  int          delay_m[NS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic valid_m(input int ch);
    logic [39:0] f;
    int s;
    f = frame_m[ch];
    s = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
    return (kind_m[ch] == 0) && (s == int'(f[7:0]));
  endfunction

  function automatic logic [15:0] predict(input logic [7:0] cmd, input int idx);
    logic [15:0] r;
    logic [39:0] f;
    logic v;
    if (idx >= NS) return 16'hEDED;
    f = frame_m[idx];
    v = valid_m(idx);
    case (cmd)
      8'h00: r = {8'h10, v ? 8'h11 : 8'h12};
      8'h01: r = v ? {8'h13, f[23:16]} : {8'hE1, 8'(idx)};
      8'h02: r = v ? {8'h14, f[39:32]} : {8'hE1, 8'(idx)};
      8'h03: begin mode_m[idx] = 1; r = 16'h15CA; end
      8'h04: begin mode_m[idx] = 2; r = 16'h16CA; end
      8'h05: if (mode_m[idx] == 1) begin mode_m[idx] = 0; r = 16'h17CA; end
             else r = 16'h17EA;
      8'h06: if (mode_m[idx] == 2) begin mode_m[idx] = 0; r = 16'h18CA; end
             else r = 16'h18EA;
      default: r = 16'hECEC;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] predict_poll(input int ch);
    logic [39:0] f;
    f = frame_m[ch];
    if (!valid_m(ch)) return {8'hE1, 8'(ch)};
    return (mode_m[ch] == 1) ? {8'h13, f[23:16]} : {8'h14, f[39:32]};
  endfunction

  task automatic set_sensor(input int ch, input logic [39:0] f, input int kind, input int dly);
    frame_m[ch] = f;
    kind_m[ch]  = kind;
    delay_m[ch] = dly;
    bus.sensor_data[40*ch +: 40] = f;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Waits for IDLE, then presents a one-cycle command; returns in cycle T+1.
  task automatic issue(input logic [7:0] cmd, input int idx, input bit expect_resp);
    int n = 0;
    while (bus.busy && n < 2000) begin step(1); n++; end
    if (bus.busy) check("issue_idle_wait", 32'(bus.busy), 0);
    if (expect_resp) exp_q.push_back(predict(cmd, idx));
    bus.request_valid = 1'b1;
    bus.request       = cmd;
    bus.device_index  = IW'(idx);
    step(1);
    bus.request_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < bound) begin step(1); n++; end
    if (exp_q.size() != 0 || bus.busy) begin
      check("drain_pending", 32'(exp_q.size()), 0);
      check("drain_busy", 32'(bus.busy), 0);
    end
  endtask

  // Sensor model: asserts done or error for one cycle after delay cycles of enable.
  initial begin
    int cnt[NS];
    bus.sensor_done  = '0;
    bus.sensor_error = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NS; i++) begin
        if (bus.sensor_enable[i]) begin
          cnt[i]++;
          bus.sensor_done[i]  = (kind_m[i] == 0) && (cnt[i] == delay_m[i]);
          bus.sensor_error[i] = (kind_m[i] == 1) && (cnt[i] == delay_m[i]);
        end else begin
          cnt[i] = 0;
          bus.sensor_done[i]  = 1'b0;
          bus.sensor_error[i] = 1'b0;
        end
      end
    end
  end

  // Monitor
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (bus.response_valid) begin
        stamp_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_response: got %0h/%0h expected none",
                   bus.response_code, bus.response);
        end else begin
          e = exp_q.pop_front();
          check("response", {16'h0, bus.response_code, bus.response}, {16'h0, e});
          check("enable_at_strobe", 32'(bus.sensor_enable), 0);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, base;
    logic seen;
    logic [7:0] h, hf, t, tf, ck;
    int s;

    bus.request_valid = 1'b0;
    bus.request       = '0;
    bus.device_index  = '0;
    bus.sensor_data   = '0;
    for (int i = 0; i < NS; i++) begin
      mode_m[i] = 0;
      set_sensor(i, 40'h0, 0, 5);
    end

    // Reset values
    step(3);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_valid", 32'(bus.response_valid), 0);
    check("rst_response", 32'(bus.response), 0);
    check("rst_code", 32'(bus.response_code), 0);
    check("rst_enable", 32'(bus.sensor_enable), 0);
    rst = 1'b0;
    step(2);

    // Basic temperature read with enable timing
    set_sensor(0, {8'h37, 8'h00, 8'h19, 8'h00, 8'h50}, 0, 10);
    issue(8'h01, 0, 1);
    check("busy_T1", 32'(bus.busy), 1);
    check("enable_T1", 32'(bus.sensor_enable), 0);
    step(1);
    check("enable_T2", 32'(bus.sensor_enable), 32'h1);
    drain(300);

    // Checksum mismatch, error, timeout on ch1
    set_sensor(1, {8'h37, 8'h00, 8'h19, 8'h00, 8'h51}, 0, 5);
    issue(8'h00, 1, 1);
    drain(300);
    set_sensor(1, {8'h37, 8'h00, 8'h19, 8'h00, 8'h50}, 1, 5);
    issue(8'h00, 1, 1);
    drain(300);
    set_sensor(1, {8'h37, 8'h00, 8'h19, 8'h00, 8'h50}, 2, 5);
    issue(8'h00, 1, 1);
    k = 0;
    while (!bus.response_valid && k < RT + 50) begin step(1); k++; end
    check("timeout_latency", 32'(k), 32'(RT + 1));
    drain(300);

    // Monitor mode on/off without polls
    base = stamp_q.size();
    issue(8'h05, 0, 1);
    issue(8'h03, 0, 1);
    issue(8'h05, 0, 1);
    drain(100);
    step(250);
    check("no_poll_after_off", 32'(stamp_q.size()), 32'(base + 3));

    // Periodic polling, ch0 temp then ch1 hum
    set_sensor(0, {8'h37, 8'h00, 8'h19, 8'h00, 8'h50}, 0, 3);
    set_sensor(1, {8'h40, 8'h05, 8'h20, 8'h01, 8'h66}, 0, 4);
    base = stamp_q.size();
    issue(8'h03, 0, 1);
    issue(8'h04, 1, 1);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(predict_poll(0));
      exp_q.push_back(predict_poll(1));
    end
    drain(600);
    if (stamp_q.size() >= base + 5)
      check("poll_period", stamp_q[base+4] - stamp_q[base+2], 32'(PP));
    else
      check("poll_count", 32'(stamp_q.size()), 32'(base + 5));
    issue(8'h05, 0, 1);
    issue(8'h06, 1, 1);
    drain(100);
    base = stamp_q.size();
    step(250);
    check("poll_stopped", 32'(stamp_q.size()), 32'(base));

    // Request beats a pending poll in the same IDLE cycle
    set_sensor(0, {8'h37, 8'h00, 8'h19, 8'h00, 8'h50}, 0, 150);
    issue(8'h04, 1, 1);
    issue(8'h01, 0, 1);
    k = 0;
    while (!bus.response_valid && k < 400) begin step(1); k++; end
    check("long_read_done", 32'(bus.response_valid), 1);
    step(1);
    exp_q.push_back(predict(8'h09, 0));
    exp_q.push_back(predict_poll(1));
    bus.request_valid = 1'b1;
    bus.request       = 8'h09;
    bus.device_index  = '0;
    step(1);
    bus.request_valid = 1'b0;
    drain(300);
    issue(8'h06, 1, 1);
    drain(100);

    // request_valid while busy is ignored
    set_sensor(0, {8'h37, 8'h00, 8'h19, 8'h00, 8'h50}, 0, 10);
    issue(8'h02, 0, 1);
    step(3);
    bus.request_valid = 1'b1;
    bus.request       = 8'h09;
    step(1);
    bus.request_valid = 1'b0;
    drain(100);
    step(20);

    // Out-of-range index, unknown command with strobe timing
    issue(8'h00, NS, 1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.sensor_enable != '0) seen = 1'b1;
      step(1);
    end
    check("oor_no_enable", 32'(seen), 0);
    drain(50);
    issue(8'h09, 0, 1);
    step(1);
    check("nonread_valid_T2", 32'(bus.response_valid), 1);
    step(1);
    check("nonread_busy_T3", 32'(bus.busy), 0);
    drain(50);

    // Randomized commands
    for (int it = 0; it < 80; it++) begin
      for (int c = 0; c < NS; c++) begin
        h = 8'($urandom); hf = 8'($urandom); t = 8'($urandom); tf = 8'($urandom);
        s = (int'(h) + int'(hf) + int'(t) + int'(tf)) % 256;
        ck = ($urandom % 2 == 0) ? 8'(s) : 8'((s + 1 + $urandom % 255) % 256);
        set_sensor(c, {h, hf, t, tf, ck}, int'($urandom % 2), 1 + int'($urandom % 20));
      end
      k = int'($urandom % 4);
      case ($urandom % 10)
        0: issue(8'h00, k, 1);
        1: issue(8'h01, k, 1);
        2: issue(8'h02, k, 1);
        3: begin issue(8'h03, k, 1); issue(8'h05, k, 1); end
        4: begin issue(8'h04, k, 1); issue(8'h06, k, 1); end
        5: issue(8'h05, k, 1);
        6: issue(8'h06, k, 1);
        default: issue(8'(7 + $urandom % 249), k, 1);
      endcase
      drain(200);
    end

    // Reset in the middle of a read
    set_sensor(0, 40'h0, 2, 5);
    issue(8'h00, 0, 0);
    step(1);
    check("midread_enable", 32'(bus.sensor_enable), 32'h1);
    #2 rst = 1'b1;
    #1 check("midread_rst_enable", 32'(bus.sensor_enable), 0);
    check("midread_rst_busy", 32'(bus.busy), 0);
    step(2);
    rst = 1'b0;
    for (int i = 0; i < NS; i++) mode_m[i] = 0;
    step(50);

    check("leftover_expected", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
